// File: rtl/score_pkg.sv
// Shared types and constants for the scoreboard button sequencer.
package score_pkg;

   localparam int DIGIT_W = 4;
   localparam int N_BTN   = 4;
   localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ARMING    = 3'd1,
      PRESSED   = 3'd2,
      HELD      = 3'd3,
      RELEASING = 3'd4
   } btn_state_t;

   typedef struct packed {
      logic                carry;
      logic [DIGIT_W-1:0]  digit;
   } bcd_sum_t;

   // Adds up to two unit increments to a BCD digit (0..11 range), folding back by ten.
   function automatic bcd_sum_t bcd_add(input logic [DIGIT_W-1:0] d,
                                        input logic inc_a,
                                        input logic inc_b);
      bcd_sum_t res;
      logic [DIGIT_W:0] sum;
      logic [DIGIT_W:0] folded;
      sum    = {1'b0, d} + {{DIGIT_W{1'b0}}, inc_a} + {{DIGIT_W{1'b0}}, inc_b};
      folded = sum - 5'd10;
      if (sum > {1'b0, BCD_MAX}) begin
         res.carry = 1'b1;
         res.digit = folded[DIGIT_W-1:0];
      end else begin
         res.carry = 1'b0;
         res.digit = sum[DIGIT_W-1:0];
      end
      return res;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button: 2-FF synchroniser, debounce FSM and long-hold detector.
// Emits single-cycle inc on an accepted press and clr on a long hold.
module btn_debounce
   import score_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int HOLD_CYCLES     = 100_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic inc,
   output logic clr,
   output logic pressed
);

   localparam int CW = $clog2(HOLD_CYCLES + 1);
   // The entry transition already consumed one stable sample, hence the -2.
   localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 2);
   localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

   logic [1:0]    sync;
   logic          s;
   btn_state_t    state;
   logic [CW-1:0] cnt;
   logic          from_held;

   assign s       = sync[1];
   assign pressed = (state == PRESSED) || (state == HELD) || (state == RELEASING);

   always_ff @(posedge clk) begin
      if (rst) begin
         sync      <= 2'b00;
         state     <= IDLE;
         cnt       <= '0;
         from_held <= 1'b0;
         inc       <= 1'b0;
         clr       <= 1'b0;
      end else begin
         sync <= {sync[0], btn};
         inc  <= 1'b0;
         clr  <= 1'b0;
         case (state)
            IDLE: begin
               if (s) begin
                  state <= ARMING;
                  cnt   <= '0;
               end
            end
            ARMING: begin
               if (!s) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else if (cnt == DEB_LAST) begin
                  state <= PRESSED;
                  cnt   <= '0;
                  inc   <= 1'b1;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            PRESSED: begin
               if (!s) begin
                  state     <= RELEASING;
                  cnt       <= '0;
                  from_held <= 1'b0;
               end else if (cnt == HOLD_LAST) begin
                  state <= HELD;
                  cnt   <= '0;
                  clr   <= 1'b1;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            HELD: begin
               if (!s) begin
                  state     <= RELEASING;
                  cnt       <= '0;
                  from_held <= 1'b1;
               end
            end
            RELEASING: begin
               // A glitch during release resumes the prior state with a fresh hold count.
               if (s) begin
                  if (from_held) state <= HELD;
                  else           state <= PRESSED;
                  cnt <= '0;
               end else if (cnt == DEB_LAST) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/score_ctrl.sv
// Scoreboard digit registers driven by four debounced buttons.
// Define SCORE_BCD_EN for two 2-digit BCD scores; default is four independent hex digits.
module score_ctrl
   import score_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int HOLD_CYCLES     = 100_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  btn,
   output logic [15:0] num,
   output logic [3:0]  point,
   output logic        updated
);

   logic [N_BTN-1:0]         inc;
   logic [N_BTN-1:0]         clr;
   logic [N_BTN*DIGIT_W-1:0] num_next;

   for (genvar i = 0; i < N_BTN; i++) begin : g_btn
      btn_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .HOLD_CYCLES    (HOLD_CYCLES)
      ) u_btn (
         .clk    (clk),
         .rst    (rst),
         .btn    (btn[i]),
         .inc    (inc[i]),
         .clr    (clr[i]),
         .pressed(point[i])
      );
   end

`ifdef SCORE_BCD_EN
   bcd_sum_t lo_sum;
   bcd_sum_t hi_sum;

   // Pair p is {d(2p+1), d(2p)}; the low digit carries into the high one, which drops its own carry.
   always_comb begin
      num_next = num;
      lo_sum   = '0;
      hi_sum   = '0;
      for (int p = 0; p < N_BTN / 2; p++) begin
         lo_sum = bcd_add(num[2*p*DIGIT_W +: DIGIT_W], inc[2*p], 1'b0);
         hi_sum = bcd_add(num[(2*p+1)*DIGIT_W +: DIGIT_W], inc[2*p+1], lo_sum.carry);
         num_next[2*p*DIGIT_W +: DIGIT_W]     = clr[2*p]   ? '0 : lo_sum.digit;
         num_next[(2*p+1)*DIGIT_W +: DIGIT_W] = clr[2*p+1] ? '0 : hi_sum.digit;
      end
   end
`else
   always_comb begin
      num_next = num;
      for (int i = 0; i < N_BTN; i++) begin
         if (clr[i]) begin
            num_next[i*DIGIT_W +: DIGIT_W] = '0;
         end else if (inc[i]) begin
            num_next[i*DIGIT_W +: DIGIT_W] = num[i*DIGIT_W +: DIGIT_W] + DIGIT_W'(1);
         end
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         num     <= '0;
         updated <= 1'b0;
      end else begin
         num     <= num_next;
         updated <= (num_next != num);
      end
   end

endmodule

// File: tb/tb_score_ctrl.sv
// Directed bench for score_ctrl with a scoreboard of expected num values.
// Build with SCORE_BCD_EN defined to exercise the BCD carry path instead of hex wrap.
`timescale 1ns/1ps
module tb_score_ctrl;

   logic        clk;
   logic        rst;
   logic [3:0]  btn;
   logic [15:0] num;
   logic [3:0]  point;
   logic        updated;

   int          checks;
   int          failures;
   logic [15:0] sb [$];
   logic [15:0] mon_exp;
   int          md [4];

   score_ctrl #(
      .DEBOUNCE_CYCLES(4),
      .HOLD_CYCLES    (20)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .btn    (btn),
      .num    (num),
      .point  (point),
      .updated(updated)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] mask, input int hold, input int gap);
      @(negedge clk);
      btn = mask;
      repeat (hold) @(negedge clk);
      btn = 4'b0000;
      repeat (gap) @(negedge clk);
   endtask

   function automatic logic [15:0] model_num();
      return {4'(md[3]), 4'(md[2]), 4'(md[1]), 4'(md[0])};
   endfunction

   function automatic void model_press(input logic [3:0] mask);
`ifdef SCORE_BCD_EN
      int lo;
      int hi;
      lo = md[1] * 10 + md[0];
      hi = md[3] * 10 + md[2];
      lo = (lo + (mask[0] ? 1 : 0) + (mask[1] ? 10 : 0)) % 100;
      hi = (hi + (mask[2] ? 1 : 0) + (mask[3] ? 10 : 0)) % 100;
      md[0] = lo % 10;
      md[1] = lo / 10;
      md[2] = hi % 10;
      md[3] = hi / 10;
`else
      for (int i = 0; i < 4; i++) begin
         if (mask[i]) md[i] = (md[i] + 1) % 16;
      end
`endif
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 4; i++) md[i] = 0;
   endfunction

   task automatic press(input logic [3:0] mask);
      model_press(mask);
      sb.push_back(model_num());
      applyStimulus(mask, 10, 10);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   // Every updated strobe must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!rst && updated) begin
         checks++;
         assert (sb.size() != 0) else begin
            failures++;
            $error("[TB] FAIL unexpected_update observed=%h expected=none", num);
         end
         if (sb.size() != 0) begin
            mon_exp = sb.pop_front();
            checkOutput("scoreboard", num, mon_exp);
         end
      end
   end

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      btn      = 4'b0000;
      model_reset();

      repeat (2) @(negedge clk);
      checkOutput("reset_num", num, 16'h0000);
      checkOutput("reset_point", {12'd0, point}, 16'h0000);
      checkOutput("reset_updated", {15'd0, updated}, 16'h0000);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      $display("[TB] clean press latency");
      @(negedge clk);
      btn = 4'b0001;
      model_press(4'b0001);
      sb.push_back(model_num());
      repeat (6) @(posedge clk);
      #1;
      checkOutput("pre_latency_num", num, 16'h0000);
      @(posedge clk);
      #1;
      checkOutput("latency_num", num, 16'h0001);
      checkOutput("latency_updated", {15'd0, updated}, 16'h0001);
      @(posedge clk);
      #1;
      checkOutput("updated_one_cycle", {15'd0, updated}, 16'h0000);
      checkOutput("point0_pressed", {12'd0, point}, 16'h0001);
      repeat (2) @(negedge clk);
      btn = 4'b0000;
      repeat (10) @(negedge clk);
      checkOutput("point0_released", {12'd0, point}, 16'h0000);

      $display("[TB] bounce rejection");
      for (int k = 0; k < 10; k++) begin
         btn[1] = ~btn[1];
         repeat (2) @(negedge clk);
      end
      btn = 4'b0000;
      repeat (10) @(negedge clk);
      checkOutput("bounce_num", num, model_num());
      checkOutput("bounce_point", {12'd0, point}, 16'h0000);

      $display("[TB] long hold clear");
      do_reset();
      checkOutput("reset_again_num", num, 16'h0000);
      for (int k = 0; k < 3; k++) press(4'b0100);
      checkOutput("three_presses", num, 16'h0300);
      model_press(4'b0100);
      sb.push_back(model_num());
      md[2] = 0;
      sb.push_back(model_num());
      applyStimulus(4'b0100, 30, 10);
      checkOutput("hold_clear", num, 16'h0000);
      checkOutput("hold_point", {12'd0, point}, 16'h0000);

      $display("[TB] reset mid-arming");
      @(negedge clk);
      btn = 4'b1000;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      btn = 4'b0000;
      model_reset();
      repeat (15) @(negedge clk);
      checkOutput("rst_mid_arming", num, 16'h0000);

`ifdef SCORE_BCD_EN
      $display("[TB] BCD carry");
      for (int k = 0; k < 9; k++) press(4'b0001);
      checkOutput("bcd_09", num, 16'h0009);
      press(4'b0011);
      checkOutput("bcd_dual_carry", num, 16'h0020);
      for (int k = 0; k < 7; k++) press(4'b0010);
      for (int k = 0; k < 9; k++) press(4'b0001);
      checkOutput("bcd_99", num, 16'h0099);
      press(4'b0001);
      checkOutput("bcd_carry_dropped", num, 16'h0000);
`else
      $display("[TB] hex wrap");
      press(4'b0100);
      checkOutput("hex_d2_set", num, 16'h0100);
      for (int k = 0; k < 16; k++) press(4'b1000);
      checkOutput("hex_wrap", num, 16'h0100);
`endif

      repeat (10) @(negedge clk);
      checkOutput("sb_drained", 16'(sb.size()), 16'h0000);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
